keypad_scan: RTL and testbench

Matrix-keypad scanner for the 4x4 keyboard that drives the onehot-to-display decoder. It walks an active-low row strobe, synchronizes and samples the column returns, and rejects bounce and multi-key ghosting. It presents a debounced 16-bit one-hot key code plus a one-cycle new-key strobe. It sits between the board keypad pins and the decoder's `onehot` input.

---
 rtl/keypad_scan.sv | 176 +++++++++++++++++
 tb/tb_keypad_scan.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//   Scanner for a 4x4 matrix keypad. Walks an active-low row strobe and samples
//   the synchronized column returns at the end of each row dwell. It assembles
//   a 16-bit frame and rejects frames with zero or several keys down. It also
//   debounces the result over DEBOUNCE_FRAMES identical frames before
//   presenting it as a one-hot key code.
//
// Parameters
//   SCAN_DIV        clk cycles per row dwell
//   DEBOUNCE_FRAMES identical frames required before onehot changes
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   col[3:0]   in   column returns, active-low, asynchronous to clk
//   row[3:0]   out  row strobe, exactly one bit low
//   onehot     out  debounced key, bit 4*row+col; 0 = no key
//   key_event  out  one-cycle pulse when onehot takes a new nonzero value
//
// Handshake: none. key_event is a single-cycle strobe that is qualified by the
// onehot value presented in the same cycle. There is no back-pressure.
// -----------------------------------------------------------------------------
module keypad_scan #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [15:0] onehot,
   output logic        key_event
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ROW0 = 2'd0,
      ROW1 = 2'd1,
      ROW2 = 2'd2,
      ROW3 = 2'd3
   } row_state_e;

   // Column synchronizer
   logic [3:0]       col_meta_q;
   logic [3:0]       col_s_q;

   // Scan and debounce state
   logic [DIV_W-1:0] div_q, div_d;
   row_state_e       state_q, state_d;
   logic [11:0]      frame_q, frame_d;
   logic [15:0]      prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      onehot_q, onehot_d;
   logic             key_event_q, key_event_d;

   // Combinational helpers
   logic             tick;
   logic [3:0]       keys_row;
   logic [15:0]      full;
   logic [15:0]      cand;
   logic [CNT_W-1:0] cnt_upd;
   logic [15:0]      prev_upd;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_q <= 4'b1111;
         col_s_q    <= 4'b1111;
      end else begin
         col_meta_q <= col;
         col_s_q    <= col_meta_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q       <= '0;
         state_q     <= ROW0;
         frame_q     <= '0;
         prev_q      <= '0;
         cnt_q       <= CNT_MAX;
         onehot_q    <= '0;
         key_event_q <= 1'b0;
      end else begin
         div_q       <= div_d;
         state_q     <= state_d;
         frame_q     <= frame_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         onehot_q    <= onehot_d;
         key_event_q <= key_event_d;
      end
   end

   always_comb begin
      tick     = (div_q == DIV_LAST);
      div_d    = tick ? '0 : div_q + 1'b1;
      keys_row = ~col_s_q;

      // The ROW3 nibble is taken live from the sampled columns; only rows 0..2
      // need storage.
      full = {keys_row, frame_q};
      cand = (popcount16(full) == 5'd1) ? full : 16'h0000;

      // Debounce bookkeeping for the frame that completes this cycle. It is
      // only committed when the ROW3 tick fires.
      if (cand == prev_q) begin
         prev_upd = prev_q;
         cnt_upd  = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end else begin
         prev_upd = cand;
         cnt_upd  = CNT_ONE;
      end

      state_d     = state_q;
      frame_d     = frame_q;
      prev_d      = prev_q;
      cnt_d       = cnt_q;
      onehot_d    = onehot_q;
      key_event_d = 1'b0;

      case (state_q)
         ROW0: begin
            if (tick) begin
               frame_d[3:0] = keys_row;
               state_d      = ROW1;
            end
         end
         ROW1: begin
            if (tick) begin
               frame_d[7:4] = keys_row;
               state_d      = ROW2;
            end
         end
         ROW2: begin
            if (tick) begin
               frame_d[11:8] = keys_row;
               state_d       = ROW3;
            end
         end
         ROW3: begin
            if (tick) begin
               state_d = ROW0;
               prev_d  = prev_upd;
               cnt_d   = cnt_upd;
               if ((cnt_upd == CNT_MAX) && (cand != onehot_q)) begin
                  onehot_d    = cand;
                  // A release clears onehot silently. Only a new key pulses.
                  key_event_d = |cand;
               end
            end
         end
         default: state_d = ROW0;
      endcase
   end

   assign row       = ~(4'b0001 << state_q);
   assign onehot    = onehot_q;
   assign key_event = key_event_q;

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//   Bench for keypad_scan with SCAN_DIV=4 and DEBOUNCE_FRAMES=3, which gives a
//   16-cycle frame. A keypad model pulls col[c] low while row[r] is low and
//   key (r,c) is pressed. Each expected onehot transition is queued when its
//   stimulus is applied. A monitor pops the queue whenever onehot changes, and
//   it checks key_event on every pulse.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

   localparam int SCAN_DIV        = 4;
   localparam int DEBOUNCE_FRAMES = 3;

   logic        clk;
   logic        rst;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [15:0] onehot;
   logic        key_event;

   logic [15:0] keys;

   logic [15:0] exp_q[$];
   int          n_checks;
   int          n_pass;
   int          ev_count;
   logic [15:0] prev_onehot;
   logic        prev_ev;

   keypad_scan #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col),
      .row       (row),
      .onehot    (onehot),
      .key_event (key_event)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- keypad model ----------------
   always_comb begin
      col = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row[r] && keys[4*r+c]) col[c] = 1'b0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         prev_onehot = 16'h0000;
         prev_ev     = 1'b0;
      end else begin
         if (onehot !== prev_onehot) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL onehot_change: got %h, no change expected (was %h) at %0t",
                        onehot, prev_onehot, $time);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               if (onehot !== e)
                  $display("FAIL onehot_change: got %h, expected %h at %0t", onehot, e, $time);
               else
                  n_pass++;
            end
            prev_onehot = onehot;
         end
         if (key_event === 1'b1) begin
            ev_count++;
            n_checks++;
            if (prev_ev || (onehot == 16'h0000))
               $display("FAIL key_event_rule: pulse with prev_ev=%b onehot=%h, expected prev_ev=0 onehot!=0 at %0t",
                        prev_ev, onehot, $time);
            else
               n_pass++;
         end
         prev_ev = key_event;
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      int bad_out;
      logic [3:0] exp_row;
      bad_out = 0;
      rst  = 1'b1;
      keys = 16'h0000;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (row !== 4'b1110) $display("FAIL reset_row: got %b, expected 1110", row);
      else n_pass++;
      n_checks++;
      if (onehot !== 16'h0000) $display("FAIL reset_onehot: got %h, expected 0000", onehot);
      else n_pass++;
      n_checks++;
      if (key_event !== 1'b0) $display("FAIL reset_key_event: got %b, expected 0", key_event);
      else n_pass++;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         n_checks++;
         if (row !== exp_row) $display("FAIL scan_row[%0d]: got %b, expected %b", k, row, exp_row);
         else n_pass++;
         if (onehot !== 16'h0000 || key_event !== 1'b0) bad_out++;
      end
      n_checks++;
      if (bad_out != 0) $display("FAIL scan_idle_outputs: got %0d bad cycles, expected 0", bad_out);
      else n_pass++;
   endtask

   task automatic test_single_press();
      int ev0;
      bit found;
      ev0   = ev_count;
      found = 1'b0;
      exp_q.push_back(16'h0040);
      keys = 16'h0040;
      for (int k = 1; k <= 66 && !found; k++) begin
         @(negedge clk);
         #1;
         if (onehot === 16'h0040) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("FAIL press_latency: got onehot=%h after 66 cycles, expected 0040", onehot);
      else n_pass++;
      repeat (200) @(negedge clk);
      #1;
      n_checks++;
      if (onehot !== 16'h0040) $display("FAIL press_hold: got %h, expected 0040", onehot);
      else n_pass++;
      n_checks++;
      if (ev_count - ev0 != 1) $display("FAIL press_pulses: got %0d, expected 1", ev_count - ev0);
      else n_pass++;
   endtask

   task automatic test_release();
      int ev0;
      bit found;
      ev0   = ev_count;
      found = 1'b0;
      exp_q.push_back(16'h0000);
      keys = 16'h0000;
      for (int k = 1; k <= 80 && !found; k++) begin
         @(negedge clk);
         #1;
         if (onehot === 16'h0000) found = 1'b1;
      end
      repeat (16) @(negedge clk);
      #1;
      n_checks++;
      if (!found) $display("FAIL release_clear: got %h, expected 0000", onehot);
      else n_pass++;
      n_checks++;
      if (ev_count != ev0) $display("FAIL release_pulses: got %0d, expected 0", ev_count - ev0);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int ev0;
      int bad;
      bit found;
      ev0   = ev_count;
      bad   = 0;
      found = 1'b0;
      // A 6-cycle toggle against a 16-cycle frame keeps any three consecutive
      // ROW3 samples from agreeing.
      for (int t = 0; t < 12; t++) begin
         keys = (t % 2 == 0) ? 16'h1000 : 16'h0000;
         repeat (6) begin
            @(negedge clk);
            #1;
            if (onehot !== 16'h0000) bad++;
         end
      end
      n_checks++;
      if (bad != 0) $display("FAIL bounce_quiet: got %0d nonzero cycles, expected 0", bad);
      else n_pass++;
      exp_q.push_back(16'h1000);
      keys = 16'h1000;
      for (int k = 1; k <= 80 && !found; k++) begin
         @(negedge clk);
         #1;
         if (onehot === 16'h1000) found = 1'b1;
      end
      repeat (32) @(negedge clk);
      #1;
      n_checks++;
      if (!found) $display("FAIL bounce_settle: got %h, expected 1000", onehot);
      else n_pass++;
      n_checks++;
      if (ev_count - ev0 != 1) $display("FAIL bounce_pulses: got %0d, expected 1", ev_count - ev0);
      else n_pass++;
   endtask

   task automatic test_ghost();
      int ev0;
      int bad;
      bit found;
      ev0 = ev_count;
      bad = 0;
      keys = 16'h8001;
      repeat (80) begin
         @(negedge clk);
         #1;
         if (onehot !== 16'h0000) bad++;
      end
      keys = 16'h0000;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (onehot !== 16'h0000) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL ghost_idle: got %0d nonzero cycles, expected 0", bad);
      else n_pass++;
      n_checks++;
      if (ev_count != ev0) $display("FAIL ghost_idle_pulses: got %0d, expected 0", ev_count - ev0);
      else n_pass++;

      ev0   = ev_count;
      found = 1'b0;
      exp_q.push_back(16'h0040);
      keys = 16'h0040;
      for (int k = 1; k <= 80 && !found; k++) begin
         @(negedge clk);
         #1;
         if (onehot === 16'h0040) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("FAIL ghost_base_key: got %h, expected 0040", onehot);
      else n_pass++;
      found = 1'b0;
      exp_q.push_back(16'h0000);
      keys = 16'h8041;
      for (int k = 1; k <= 80 && !found; k++) begin
         @(negedge clk);
         #1;
         if (onehot === 16'h0000) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("FAIL ghost_reject: got %h, expected 0000", onehot);
      else n_pass++;
      n_checks++;
      if (ev_count - ev0 != 1) $display("FAIL ghost_pulses: got %0d, expected 1", ev_count - ev0);
      else n_pass++;
   endtask

   task automatic test_direct_change();
      int ev0;
      bit found;
      found = 1'b0;
      exp_q.push_back(16'h0040);
      keys = 16'h0040;
      for (int k = 1; k <= 80 && !found; k++) begin
         @(negedge clk);
         #1;
         if (onehot === 16'h0040) found = 1'b1;
      end
      n_checks++;
      if (!found) $display("FAIL change_from: got %h, expected 0040", onehot);
      else n_pass++;
      ev0   = ev_count;
      found = 1'b0;
      exp_q.push_back(16'h0200);
      keys = 16'h0200;
      for (int k = 1; k <= 80 && !found; k++) begin
         @(negedge clk);
         #1;
         if (onehot === 16'h0200) found = 1'b1;
      end
      repeat (32) @(negedge clk);
      #1;
      n_checks++;
      if (!found) $display("FAIL change_to: got %h, expected 0200", onehot);
      else n_pass++;
      n_checks++;
      if (ev_count - ev0 != 1) $display("FAIL change_pulses: got %0d, expected 1", ev_count - ev0);
      else n_pass++;
   endtask

   task automatic test_reset_mid_debounce();
      int bad;
      bad  = 0;
      keys = 16'h0008;
      repeat (16) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (row !== 4'b1110) $display("FAIL midrst_row: got %b, expected 1110", row);
      else n_pass++;
      n_checks++;
      if (onehot !== 16'h0000 || key_event !== 1'b0)
         $display("FAIL midrst_outputs: got onehot=%h key_event=%b, expected 0000/0", onehot, key_event);
      else n_pass++;
      repeat (2) @(negedge clk);
      #1;
      exp_q.push_back(16'h0008);
      rst = 1'b0;
      // Three complete frames after release: qualification lands on edge 48.
      for (int k = 1; k <= 47; k++) begin
         @(negedge clk);
         #1;
         if (onehot !== 16'h0000) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL midrst_early: got %0d early cycles, expected 0", bad);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if (onehot !== 16'h0008 || key_event !== 1'b1)
         $display("FAIL midrst_qualify: got onehot=%h key_event=%b, expected 0008/1", onehot, key_event);
      else n_pass++;
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      ev_count    = 0;
      prev_onehot = 16'h0000;
      prev_ev     = 1'b0;
      rst         = 1'b1;
      keys        = 16'h0000;

      test_reset();
      test_single_press();
      test_release();
      test_bounce();
      test_release();
      test_ghost();
      test_direct_change();
      test_release();
      test_reset_mid_debounce();

      repeat (4) @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      else n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
